data_access_rx: RTL and testbench

//  Receive-side counterpart of data_access: reassembles byte stream from the RS232

---
 rtl/data_access_rx.sv | 131 +++++++++++++
 tb/tb_data_access_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_access_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | data_access_rx: reassembles RS232 Rx bytes into {type[1:0], data[13:0]}.     |
// | Optional RX_CHECKSUM_EN adds a third byte CK = B0 ^ B1.   Revision: 1.0      |
// +-----------------------------------------------------------------------------+
module data_access_rx #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rs232_Data_out,
  input  logic        rs232_Data_out_valid,
  input  logic        da_Ready_for_Data_out,
  output logic [13:0] da_Data_out,
  output logic [1:0]  da_sensor_type,
  output logic        da_Data_out_valid,
  output logic        da_overrun,
  output logic        da_frame_error
);

  localparam logic [TO_W-1:0] c_timeout = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_B0 = 2'd1,
    GOT_B1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_b0;
  logic [TO_W-1:0] r_cnt;
  logic            w_expire;
  logic            w_frame_done;
  logic            w_ck_bad;
  logic [15:0]     w_sample;

`ifdef RX_CHECKSUM_EN
  logic [7:0]      r_b1;
  assign w_sample = {r_b0, r_b1};
`else
  assign w_sample = {r_b0, rs232_Data_out};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Expiry takes priority: a strobe on the expiry cycle restarts a frame as B0.
  always_comb begin
    w_next       = r_state;
    w_frame_done = 1'b0;
    w_ck_bad     = 1'b0;
    w_expire     = (r_state != IDLE) && (r_cnt == c_timeout);
    case (r_state)
      IDLE: begin
        if (rs232_Data_out_valid) w_next = GOT_B0;
      end
      GOT_B0: begin
        if (w_expire) begin
          w_next = rs232_Data_out_valid ? GOT_B0 : IDLE;
        end else if (rs232_Data_out_valid) begin
`ifdef RX_CHECKSUM_EN
          w_next = GOT_B1;
`else
          w_next       = IDLE;
          w_frame_done = 1'b1;
`endif
        end
      end
`ifdef RX_CHECKSUM_EN
      GOT_B1: begin
        if (w_expire) begin
          w_next = rs232_Data_out_valid ? GOT_B0 : IDLE;
        end else if (rs232_Data_out_valid) begin
          w_next = IDLE;
          if (rs232_Data_out == (r_b0 ^ r_b1)) w_frame_done = 1'b1;
          else                                 w_ck_bad     = 1'b1;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_b0              <= '0;
`ifdef RX_CHECKSUM_EN
      r_b1              <= '0;
`endif
      r_cnt             <= '0;
      da_Data_out       <= '0;
      da_sensor_type    <= '0;
      da_Data_out_valid <= 1'b0;
      da_overrun        <= 1'b0;
      da_frame_error    <= 1'b0;
    end else begin
      da_overrun     <= 1'b0;
      da_frame_error <= w_expire | w_ck_bad;

      if (rs232_Data_out_valid && (w_next == GOT_B0)) r_b0 <= rs232_Data_out;
`ifdef RX_CHECKSUM_EN
      if (rs232_Data_out_valid && (w_next == GOT_B1)) r_b1 <= rs232_Data_out;
`endif

      if (rs232_Data_out_valid || (w_next == IDLE)) r_cnt <= '0;
      else                                          r_cnt <= r_cnt + TO_W'(1);

      // A held, unaccepted sample wins over a newly completed frame.
      if (w_frame_done) begin
        if (!da_Data_out_valid || da_Ready_for_Data_out) begin
          da_Data_out       <= w_sample[13:0];
          da_sensor_type    <= w_sample[15:14];
          da_Data_out_valid <= 1'b1;
        end else begin
          da_overrun <= 1'b1;
        end
      end else if (da_Data_out_valid && da_Ready_for_Data_out) begin
        da_Data_out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_access_rx.sv
`default_nettype none
// Scoreboard bench for data_access_rx; expected samples queued at stimulus time.
module tb_data_access_rx;

  localparam int TO = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rs232_Data_out = 8'h00;
  logic        rs232_Data_out_valid = 1'b0;
  logic        da_Ready_for_Data_out = 1'b0;
  logic [13:0] da_Data_out;
  logic [1:0]  da_sensor_type;
  logic        da_Data_out_valid;
  logic        da_overrun;
  logic        da_frame_error;

  int n_checks = 0;
  int n_errors = 0;
  int n_overrun = 0;
  int n_ferr = 0;
  logic [15:0] exp_q[$];

  data_access_rx #(.TIMEOUT_CYCLES(TO), .TO_W(10)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .rs232_Data_out        (rs232_Data_out),
    .rs232_Data_out_valid  (rs232_Data_out_valid),
    .da_Ready_for_Data_out (da_Ready_for_Data_out),
    .da_Data_out           (da_Data_out),
    .da_sensor_type        (da_sensor_type),
    .da_Data_out_valid     (da_Data_out_valid),
    .da_overrun            (da_overrun),
    .da_frame_error        (da_frame_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rs232_Data_out       = b;
    rs232_Data_out_valid = 1'b1;
    tick();
    rs232_Data_out_valid = 1'b0;
  endtask

  // Expected sample: type = B0[7:6], data = {B0[5:0], B1}.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input bit expect_out);
    if (expect_out) exp_q.push_back({b0[7:6], b0[5:0], b1});
    send_byte(b0);
    send_byte(b1);
`ifdef RX_CHECKSUM_EN
    send_byte(b0 ^ b1);
`endif
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready.
  always @(negedge clock) begin
    if (reset) begin
      if (da_Data_out_valid && da_Ready_for_Data_out) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("sample_data", 32'(da_Data_out), 32'(e[13:0]));
          check("sample_type", 32'(da_sensor_type), 32'(e[15:14]));
        end
      end
      if (da_overrun)     n_overrun++;
      if (da_frame_error) n_ferr++;
    end
  end

  initial begin
    int ov0, fe0, k;
    bit seen, saw_valid, stable;

    #1 reset = 1'b0;
    tick(); tick();
    check("reset_outputs",
          {14'd0, da_Data_out, da_sensor_type, da_Data_out_valid, da_overrun, da_frame_error},
          32'd0);
    reset = 1'b1;
    tick();

    // 1: basic frame, consumer ready
    da_Ready_for_Data_out = 1'b1;
    send_frame(8'hC5, 8'hA3, 1'b1);
    check("t1_valid_latency", 32'(da_Data_out_valid), 32'd1);
    tick();
    check("t1_valid_one_cycle", 32'(da_Data_out_valid), 32'd0);
    drain("t1_drain");
    check("t1_no_frame_error", 32'(n_ferr), 32'd0);

    // 2: consumer stalls, outputs held stable
    da_Ready_for_Data_out = 1'b0;
    send_frame(8'h40, 8'h01, 1'b1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(da_Data_out_valid && da_Data_out == 14'h0001 && da_sensor_type == 2'b01)) stable = 1'b0;
      tick();
    end
    check("t2_held_stable", 32'(stable), 32'd1);
    check("t2_held_data", 32'(da_Data_out), 32'h0001);
    da_Ready_for_Data_out = 1'b1;
    tick();
    check("t2_valid_dropped", 32'(da_Data_out_valid), 32'd0);
    drain("t2_drain");

    // 3: inter-byte timeout, then recovery
    fe0 = n_ferr;
    send_byte(8'h12);
    k = 0; seen = 1'b0; saw_valid = 1'b0;
    for (int i = 0; i < TO + 50 && !seen; i++) begin
      tick();
      k++;
      if (da_frame_error)    seen = 1'b1;
      if (da_Data_out_valid) saw_valid = 1'b1;
    end
    check("t3_timeout_seen", 32'(seen), 32'd1);
    check("t3_timeout_latency", 32'(k >= TO && k <= TO + 1), 32'd1);
    check("t3_no_valid", 32'(saw_valid), 32'd0);
    tick();
    check("t3_error_pulses", 32'(n_ferr - fe0), 32'd1);
    send_frame(8'h80, 8'hFF, 1'b1);
    drain("t3_drain");

    // 4: second frame arrives while first is held -> overrun
    da_Ready_for_Data_out = 1'b0;
    ov0 = n_overrun;
    send_frame(8'h11, 8'h22, 1'b1);
    send_frame(8'h33, 8'h44, 1'b0);
    tick(); tick();
    check("t4_overrun_once", 32'(n_overrun - ov0), 32'd1);
    check("t4_held_first", 32'(da_Data_out), 32'h1122);
    check("t4_held_valid", 32'(da_Data_out_valid), 32'd1);
    da_Ready_for_Data_out = 1'b1;
    drain("t4_drain");

`ifdef RX_CHECKSUM_EN
    // 5: checksum good and bad
    send_frame(8'h3F, 8'hFF, 1'b1);
    drain("t5_good_drain");
    tick(); tick();
    fe0 = n_ferr;
    send_byte(8'h3F);
    send_byte(8'hFF);
    send_byte(8'h00);
    tick(); tick();
    check("t5_ck_error", 32'(n_ferr - fe0), 32'd1);
    check("t5_no_valid", 32'(da_Data_out_valid), 32'd0);
`endif

    // 6: reset mid-frame with a pending sample
    da_Ready_for_Data_out = 1'b0;
    send_frame(8'hAA, 8'hBB, 1'b0);
    send_byte(8'h55);
    reset = 1'b0;
    tick();
    check("t6_reset_outputs",
          {14'd0, da_Data_out, da_sensor_type, da_Data_out_valid, da_overrun, da_frame_error},
          32'd0);
    reset = 1'b1;
    da_Ready_for_Data_out = 1'b1;
    tick();
    send_frame(8'h01, 8'h02, 1'b1);
    check("t6_data", 32'(da_Data_out), 32'h0102);
    check("t6_type", 32'(da_sensor_type), 32'd0);
    drain("t6_drain");
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
